// File: rtl/banco_registros_param_if.sv
// Bus bundle for the parametrised register bank: two read ports, one
// byte-enabled write port and the clear-engine handshake.
interface banco_registros_param_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              clr_req;
    logic              busy;
    logic [ADDR_W-1:0] addr_rs1;
    logic [ADDR_W-1:0] addr_rs2;
    logic [ADDR_W-1:0] addr_rd;
    logic [DATA_W-1:0] data_in;
    logic              we;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;

    modport master (
        output clr_req, addr_rs1, addr_rs2, addr_rd, data_in, we, be,
        input  busy, rs1, rs2
    );

    modport slave (
        input  clr_req, addr_rs1, addr_rs2, addr_rd, data_in, we, be,
        output busy, rs1, rs2
    );
endinterface

// File: rtl/banco_registros_param.sv
// Parametrised 2R/1W register bank with byte enables, optional zero register,
// optional write bypass, optional registered reads and a sequential clear engine.
module banco_registros_param #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input logic                    clk,
    input logic                    rst,
    banco_registros_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_idx;
    logic              busy;
    logic              wr_ok;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] raw1;
    logic [DATA_W-1:0] raw2;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            clr_idx <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR)
                clr_idx <= clr_idx + 1'b1;
            else
                clr_idx <= '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.clr_req) state_next = CLEAR;
            CLEAR:   if (clr_idx == '1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    assign bus.busy = busy;

    always_comb begin
        wr_mask = '0;
        for (int k = 0; k < NB; k++)
            wr_mask[8*k +: 8] = {8{bus.be[k]}};
    end

    assign wr_ok = bus.we && !busy && (|bus.be) &&
                   !(ZERO_REG != 0 && bus.addr_rd == '0);

    // The clear sweep owns the array while busy, so user writes never collide with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (busy) begin
            mem[clr_idx] <= '0;
        end else if (wr_ok) begin
            mem[bus.addr_rd] <= (mem[bus.addr_rd] & ~wr_mask) | (bus.data_in & wr_mask);
        end
    end

    function automatic logic [DATA_W-1:0] read_mux(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] entry,
        input logic              blocked,
        input logic              hit_wr,
        input logic [DATA_W-1:0] mask,
        input logic [DATA_W-1:0] wdata
    );
        if (ZERO_REG != 0 && a == '0)
            return '0;
        else if (blocked)
            return '0;
        else if (BYPASS != 0 && hit_wr)
            return (entry & ~mask) | (wdata & mask);
        else
            return entry;
    endfunction

    always_comb begin
        raw1 = read_mux(bus.addr_rs1, mem[bus.addr_rs1], busy,
                        wr_ok && (bus.addr_rs1 == bus.addr_rd), wr_mask, bus.data_in);
        raw2 = read_mux(bus.addr_rs2, mem[bus.addr_rs2], busy,
                        wr_ok && (bus.addr_rs2 == bus.addr_rd), wr_mask, bus.data_in);
    end

    generate
        if (READ_LAT != 0) begin : g_reg_read
            logic [DATA_W-1:0] rs1_q;
            logic [DATA_W-1:0] rs2_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rs1_q <= '0;
                    rs2_q <= '0;
                end else begin
                    rs1_q <= raw1;
                    rs2_q <= raw2;
                end
            end

            assign bus.rs1 = rs1_q;
            assign bus.rs2 = rs2_q;
        end else begin : g_comb_read
            assign bus.rs1 = raw1;
            assign bus.rs2 = raw2;
        end
    endgenerate
endmodule

// File: doc/banco_registros_param.md
Name: banco_registros_param

Overview:
Parametrised register file with 2 read ports and 1 write port. It is the next-generation register bank for the lab datapath and adds the following over the previous bank:
- configurable depth and width
- per-byte write enables
- optional hardwired-zero register 0
- optional write-to-read bypass
- selectable combinational or registered reads
- a sequential clear engine that zeroes the array without asserting reset

Parameters:
ADDR_W, 5, address width; depth = 2**ADDR_W entries.
DATA_W, 32, entry width in bits; must be a multiple of 8; byte lanes NB = DATA_W/8.
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register.
BYPASS, 1, 1 = a read of the address being written this cycle returns the merged new data; 0 = read returns the old contents.
READ_LAT, 0, 0 = combinational read; 1 = read data registered, one cycle latency.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
clr_req  input  1  start sequential clear; sampled only in IDLE.
busy  output  1  high while clear engine is active.
addr_rs1  input  ADDR_W  read port 1 address.
addr_rs2  input  ADDR_W  read port 2 address.
addr_rd  input  ADDR_W  write address.
data_in  input  DATA_W  write data.
we  input  1  write enable.
be  input  NB  byte-lane write enables; lane k = bits [8k+7:8k].
rs1  output  DATA_W  read port 1 data.
rs2  output  DATA_W  read port 2 data.

Behaviour:
- Reset (rst=1, async):
  - every entry, including entry 0, becomes 0
  - FSM goes to IDLE; busy=0; clear index=0
  - rs1/rs2 registers (READ_LAT=1) go to 0
- Effective write (wr_ok) = we && !busy && |be && !(ZERO_REG && addr_rd==0).
  - On the clk edge, only lanes with be[k]=1 update; other lanes keep their old value.
- Write attempts while busy=1 are dropped silently; there is no queueing.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req=1 on a clk edge. Index starts at 0 and busy goes high starting the next cycle.
  - In CLEAR, each cycle writes 0 to mem[index], then index++.
  - When the cycle with index = DEPTH-1 completes, go to IDLE. busy is high for exactly DEPTH cycles.
  - clr_req in CLEAR is ignored; it does not restart the sweep.
  - rst mid-sweep aborts the sweep; the array is fully zeroed by reset anyway.
- Read value raw(a):
  - If ZERO_REG && a==0: 0.
  - Else if busy: 0. Outputs are forced to 0 for the whole sweep, regardless of which entries are already cleared.
  - Else if BYPASS && wr_ok && a==addr_rd: lanes with be=1 come from data_in, other lanes from mem[a].
  - Else: mem[a].
- READ_LAT=0: rs1=raw(addr_rs1) and rs2=raw(addr_rs2), combinationally.
- READ_LAT=1: rs1/rs2 are registered on each clk edge with the raw() value of that cycle.
- Both read ports may address the same entry, or the write entry, simultaneously; no priority conflict.
- With BYPASS=0, a same-cycle read returns the pre-write value. The new value is visible from the next cycle (READ_LAT=0) or the next-next edge (READ_LAT=1).
- Addresses wrap naturally within ADDR_W; no out-of-range case exists.

Test Plan:
All scenarios use defaults unless stated (ADDR_W=5, DATA_W=32).
1. Byte-enable write:
   - Write 0xAABBCCDD to r3 with be=4'hF.
   - Next cycle write 0x11223344 to r3 with be=4'b0101.
   - Read r3 -> 0xAA22CC44.
2. Zero register:
   - Write 0xFFFFFFFF to r0 with be=4'hF.
   - rs1 with addr_rs1=0 -> 0x0.
   - With ZERO_REG=0, the same sequence reads 0xFFFFFFFF.
3. Bypass:
   - r5=0x12345678.
   - In one cycle, write 0xDEADBEEF to r5 with be=4'b0011 while addr_rs1=addr_rs2=5.
   - BYPASS=1: rs1=rs2=0x1234BEEF in that same cycle.
   - BYPASS=0: rs1=rs2=0x12345678 in that cycle, and 0x1234BEEF in the next cycle.
4. Registered read (READ_LAT=1):
   - r7=0xCAFEF00D; set addr_rs1=7 at cycle t.
   - rs1 shows 0xCAFEF00D after edge t+1 and not before.
   - After an async rst pulse, rs1 is 0 immediately.
5. Sequential clear:
   - Fill r1..r31 with nonzero values; pulse clr_req for 1 cycle.
   - busy high for exactly 32 cycles.
   - A write to r9 issued at busy cycle 10 is dropped.
   - rs1/rs2 stay 0 while busy.
   - After busy falls, every register reads 0.
6. Reset mid-clear:
   - Assert rst at busy cycle 12.
   - busy drops immediately and all entries read 0.
   - A subsequent write of 0x5 to r2 succeeds and reads back 0x5.
